// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Frame controller that sits behind a UART byte receiver. It parses the
// frame format HEADER, CMD, LEN, LEN payload bytes, CHK and checks the length
// and the 8-bit XOR checksum. Accepted payloads are buffered, then replayed
// downstream over a valid/ready byte stream.
//
// Ports
//   sys_clk, sys_reset_n   clock, asynchronous active-low reset
//   i_rx_data/_en          received byte and its one-cycle strobe
//   o_cmd, o_len           command and length of the last accepted frame
//   o_frame_valid          one-cycle pulse when a frame passes its checksum
//   o_byte_data/_valid/_last, i_byte_ready   payload replay stream
//   o_busy                 high whenever the FSM is outside IDLE
//   o_err_chk/_len/_timeout, o_overrun       one-cycle error pulses
//
// State table
//   state     | meaning
//   S_IDLE    | hunting for the HEADER byte, other bytes ignored
//   S_CMD     | waiting for the command byte
//   S_LEN     | waiting for the payload length byte
//   S_PAYLOAD | storing payload bytes into the buffer
//   S_CHK     | waiting for the checksum byte
//   S_DRAIN   | replaying the accepted payload, incoming bytes dropped
module uart_rx_frame_ctrl #(
  parameter logic [7:0] HEADER      = 8'hAA,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic       sys_clk,
  input  logic       sys_reset_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_data_en,
  output logic [7:0] o_cmd,
  output logic [7:0] o_len,
  output logic       o_frame_valid,
  output logic [7:0] o_byte_data,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic       o_byte_last,
  output logic       o_busy,
  output logic       o_err_chk,
  output logic       o_err_len,
  output logic       o_err_timeout,
  output logic       o_overrun
);

  // Buffer address width; kept at least one bit so MAX_LEN=1 still elaborates.
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_LEN     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CHK     = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  logic [2:0]    state;
  logic [7:0]    cmd_shadow;
  logic [7:0]    len_shadow;
  logic [7:0]    chk;
  logic [7:0]    idx;
  logic [7:0]    rd_idx;
  logic [TW-1:0] to_cnt;
  logic [7:0]    pay_mem [MAX_LEN];

  logic in_frame;
  logic timeout_hit;
  logic last_hs;

  // Only the in-frame states run the inter-byte timer.
  assign in_frame = (state == S_CMD) || (state == S_LEN) ||
                    (state == S_PAYLOAD) || (state == S_CHK);

  // A strobe in the expiry cycle wins, so expiry needs the strobe absent.
  // to_cnt equal to TIMEOUT_CYC-1 means this edge is the TIMEOUT_CYC-th idle one.
  assign timeout_hit = in_frame && !i_rx_data_en && (to_cnt == TO_LAST);

  assign o_busy       = (state != S_IDLE);
  assign o_byte_valid = (state == S_DRAIN);
  assign o_byte_data  = o_byte_valid ? pay_mem[rd_idx[AW-1:0]] : 8'h00;
  assign o_byte_last  = o_byte_valid && (rd_idx == (len_shadow - 8'd1));
  assign last_hs      = o_byte_last && i_byte_ready;

  // Payload storage needs no reset; its contents only matter once written.
  always_ff @(posedge sys_clk) begin
    if (state == S_PAYLOAD && i_rx_data_en) begin
      pay_mem[idx[AW-1:0]] <= i_rx_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      to_cnt <= '0;
    end else if (!in_frame || i_rx_data_en || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state         <= S_IDLE;
      cmd_shadow    <= 8'h00;
      len_shadow    <= 8'h00;
      chk           <= 8'h00;
      idx           <= 8'h00;
      rd_idx        <= 8'h00;
      o_cmd         <= 8'h00;
      o_len         <= 8'h00;
      o_frame_valid <= 1'b0;
      o_err_chk     <= 1'b0;
      o_err_len     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_frame_valid <= 1'b0;
      o_err_chk     <= 1'b0;
      o_err_len     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_overrun     <= 1'b0;

      if (timeout_hit) begin
        o_err_timeout <= 1'b1;
        state         <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (i_rx_data_en && (i_rx_data == HEADER)) begin
              state <= S_CMD;
            end
          end

          S_CMD: begin
            if (i_rx_data_en) begin
              cmd_shadow <= i_rx_data;
              chk        <= i_rx_data;
              state      <= S_LEN;
            end
          end

          S_LEN: begin
            if (i_rx_data_en) begin
              len_shadow <= i_rx_data;
              chk        <= chk ^ i_rx_data;
              idx        <= 8'h00;
              if (i_rx_data > MAX_LEN_B) begin
                o_err_len <= 1'b1;
                state     <= S_IDLE;
              end else if (i_rx_data == 8'h00) begin
                state <= S_CHK;
              end else begin
                state <= S_PAYLOAD;
              end
            end
          end

          S_PAYLOAD: begin
            if (i_rx_data_en) begin
              chk <= chk ^ i_rx_data;
              idx <= idx + 8'd1;
              if ((idx + 8'd1) == len_shadow) begin
                state <= S_CHK;
              end
            end
          end

          S_CHK: begin
            if (i_rx_data_en) begin
              if (i_rx_data == chk) begin
                o_cmd         <= cmd_shadow;
                o_len         <= len_shadow;
                o_frame_valid <= 1'b1;
                rd_idx        <= 8'h00;
                state         <= (len_shadow != 8'h00) ? S_DRAIN : S_IDLE;
              end else begin
                o_err_chk <= 1'b1;
                state     <= S_IDLE;
              end
            end
          end

          S_DRAIN: begin
            // No resynchronisation here: every strobe, HEADER included, is lost.
            if (i_rx_data_en) begin
              o_overrun <= 1'b1;
            end
            if (last_hs) begin
              rd_idx <= 8'h00;
              state  <= S_IDLE;
            end else if (i_byte_ready) begin
              rd_idx <= rd_idx + 8'd1;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

  localparam logic [7:0] HDR  = 8'hAA;
  localparam int         MAXL = 16;
  localparam int         TOC  = 1000;

  localparam int EV_FRAME = 0;
  localparam int EV_CHK   = 1;
  localparam int EV_LEN   = 2;
  localparam int EV_TO    = 3;

  logic       sys_clk = 1'b0;
  logic       sys_reset_n = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_data_en = 1'b0;
  logic       i_byte_ready;
  logic [7:0] o_cmd, o_len, o_byte_data;
  logic       o_frame_valid, o_byte_valid, o_byte_last, o_busy;
  logic       o_err_chk, o_err_len, o_err_timeout, o_overrun;

  uart_rx_frame_ctrl #(.HEADER(HDR), .MAX_LEN(MAXL), .TIMEOUT_CYC(TOC)) dut (
    .sys_clk       (sys_clk),
    .sys_reset_n   (sys_reset_n),
    .i_rx_data     (i_rx_data),
    .i_rx_data_en  (i_rx_data_en),
    .o_cmd         (o_cmd),
    .o_len         (o_len),
    .o_frame_valid (o_frame_valid),
    .o_byte_data   (o_byte_data),
    .o_byte_valid  (o_byte_valid),
    .i_byte_ready  (i_byte_ready),
    .o_byte_last   (o_byte_last),
    .o_busy        (o_busy),
    .o_err_chk     (o_err_chk),
    .o_err_len     (o_err_len),
    .o_err_timeout (o_err_timeout),
    .o_overrun     (o_overrun)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { int kind; logic [7:0] cmd; logic [7:0] len; } evt_t;
  typedef struct { logic [7:0] data; logic last; } byt_t;

  evt_t       exp_evt[$];
  byt_t       exp_byte[$];
  logic [7:0] frm[$];
  logic [7:0] pl[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_ovr = 0;
  int         seen_ovr = 0;
  int         idle_since = 0;
  int         rdy_mode = 3;
  logic       draining = 1'b0;
  logic [7:0] m_cmd = 8'h00;
  logic [7:0] m_len = 8'h00;

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects a whole frame as a byte list and judges it once
  // it is complete, using the frame rules directly.
  task automatic model_byte(logic [7:0] b);
    logic [7:0] x;
    int n;
    idle_since = 0;
    if (draining) begin
      exp_ovr++;
      return;
    end
    if (frm.size() == 0) begin
      if (b == HDR) frm.push_back(b);
      return;
    end
    frm.push_back(b);
    n = frm.size();
    if (n == 3 && b > MAXL) begin
      exp_evt.push_back('{EV_LEN, m_cmd, m_len});
      frm.delete();
      return;
    end
    if (n >= 4 && n == int'(frm[2]) + 4) begin
      x = 8'h00;
      for (int i = 1; i < n - 1; i++) x = x ^ frm[i];
      if (x == b) begin
        m_cmd = frm[1];
        m_len = frm[2];
        exp_evt.push_back('{EV_FRAME, m_cmd, m_len});
        for (int i = 0; i < int'(m_len); i++)
          exp_byte.push_back('{frm[3+i], (i == int'(m_len) - 1)});
        draining = (m_len != 8'h00);
      end else begin
        exp_evt.push_back('{EV_CHK, m_cmd, m_len});
      end
      frm.delete();
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    i_rx_data    = b;
    i_rx_data_en = 1'b1;
    model_byte(b);
    @(posedge sys_clk);
    #1;
    i_rx_data_en = 1'b0;
    i_rx_data    = 8'($urandom);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
      idle_since++;
      if (idle_since == TOC && frm.size() > 0) begin
        exp_evt.push_back('{EV_TO, m_cmd, m_len});
        frm.delete();
      end
    end
  endtask

  // Sends HEADER, cmd, pl.size() as LEN, the payload in pl, then the XOR
  // checksum corrupted by chk_xor.
  task automatic send_frame(logic [7:0] cmd, logic [7:0] chk_xor, int maxgap);
    logic [7:0] c;
    c = cmd ^ 8'(pl.size());
    foreach (pl[i]) c = c ^ pl[i];
    send_byte(HDR);
    idle($urandom_range(0, maxgap));
    send_byte(cmd);
    idle($urandom_range(0, maxgap));
    send_byte(8'(pl.size()));
    foreach (pl[i]) begin
      idle($urandom_range(0, maxgap));
      send_byte(pl[i]);
    end
    idle($urandom_range(0, maxgap));
    send_byte(c ^ chk_xor);
  endtask

  task automatic finish_case(string name);
    int n;
    n = 0;
    while (exp_byte.size() > 0 && n < 3000) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    if (exp_byte.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: %0d bytes never streamed, required 0", name, exp_byte.size());
      exp_byte.delete();
    end
    draining = 1'b0;
    idle(2);
    check_val({name, "_busy"}, o_busy, 0);
    check_val({name, "_valid"}, o_byte_valid, 0);
    check_val({name, "_events_left"}, exp_evt.size(), 0);
    check_val({name, "_overruns"}, seen_ovr, exp_ovr);
    exp_evt.delete();
  endtask

  task automatic check_all_zero(string name);
    check_val({name, "_cmd"}, o_cmd, 0);
    check_val({name, "_len"}, o_len, 0);
    check_val({name, "_fv"}, o_frame_valid, 0);
    check_val({name, "_bdata"}, o_byte_data, 0);
    check_val({name, "_bvalid"}, o_byte_valid, 0);
    check_val({name, "_blast"}, o_byte_last, 0);
    check_val({name, "_busy"}, o_busy, 0);
    check_val({name, "_errs"}, {o_err_chk, o_err_len, o_err_timeout, o_overrun}, 0);
  endtask

  // Downstream ready generator.
  initial begin
    i_byte_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      case (rdy_mode)
        0:       i_byte_ready = ($urandom_range(0, 3) != 0);
        1:       i_byte_ready = 1'b0;
        2:       i_byte_ready = ~i_byte_ready;
        default: i_byte_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge sys_clk) begin : mon
    int   np;
    int   kind;
    evt_t e;
    if (sys_reset_n) begin
      np = int'(o_frame_valid) + int'(o_err_chk) + int'(o_err_len) + int'(o_err_timeout);
      if (np > 1) begin
        checks++;
        errors++;
        $display("FAIL pulse_excl: %0d pulses together, required at most 1", np);
      end
      if (np > 0) begin
        kind = o_frame_valid ? EV_FRAME : o_err_chk ? EV_CHK : o_err_len ? EV_LEN : EV_TO;
        if (exp_evt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d, required none at %0t", kind, $time);
        end else begin
          e = exp_evt.pop_front();
          check_val("event_kind", kind, e.kind);
          check_val("o_cmd", o_cmd, e.cmd);
          check_val("o_len", o_len, e.len);
        end
      end
      if (o_overrun) seen_ovr++;
      if (o_byte_valid) begin
        if (exp_byte.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h, required no valid at %0t", o_byte_data, $time);
        end else begin
          check_val("byte_data", o_byte_data, exp_byte[0].data);
          check_val("byte_last", o_byte_last, exp_byte[0].last);
          if (i_byte_ready) void'(exp_byte.pop_front());
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int kind;
    int n;
    repeat (3) @(posedge sys_clk);
    #1;
    check_all_zero("in_reset");
    sys_reset_n = 1'b1;
    idle(2);
    check_all_zero("after_reset");

    // Basic two-byte frame, ready always high.
    rdy_mode = 3;
    pl = '{};
    pl.push_back(8'h10);
    pl.push_back(8'h20);
    send_frame(8'h01, 8'h00, 0);
    finish_case("basic");

    // Stall: ready low for a while, then toggling.
    rdy_mode = 1;
    i_byte_ready = 1'b0;
    send_frame(8'h01, 8'h00, 0);
    idle(5);
    rdy_mode = 2;
    finish_case("stall");

    // Zero-length frame.
    rdy_mode = 3;
    pl = '{};
    send_frame(8'h05, 8'h00, 0);
    finish_case("zero_len");

    // Bad checksum, then a junk byte followed by a good one-byte frame.
    pl = '{};
    pl.push_back(8'h10);
    pl.push_back(8'h20);
    send_frame(8'h01, 8'h07, 0);
    send_byte(8'h55);
    pl = '{};
    pl.push_back(8'h07);
    send_frame(8'h02, 8'h00, 0);
    finish_case("bad_chk");

    // Length above MAX_LEN.
    send_byte(HDR);
    send_byte(8'h01);
    send_byte(8'h11);
    finish_case("bad_len");

    // Timeout exactly TOC idle cycles after the last strobe.
    send_byte(HDR);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h10);
    for (int k = 1; k <= TOC; k++) begin
      idle(1);
      if (k >= TOC - 5) check_val("timeout_at", o_err_timeout, (k == TOC));
    end
    finish_case("timeout");

    // Overrun: strobes during a stalled drain are dropped.
    rdy_mode = 1;
    i_byte_ready = 1'b0;
    pl = '{};
    pl.push_back(8'h3C);
    pl.push_back(8'hC3);
    send_frame(8'h09, 8'h00, 1);
    idle(1);
    send_byte(8'h77);
    idle(1);
    send_byte(HDR);
    send_byte(8'h01);
    idle(2);
    check_val("overrun_count", seen_ovr, 3);
    rdy_mode = 0;
    finish_case("overrun");

    // Reset in the middle of a payload.
    rdy_mode = 3;
    send_byte(HDR);
    send_byte(8'h07);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    sys_reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    frm.delete();
    exp_evt.delete();
    exp_byte.delete();
    draining = 1'b0;
    m_cmd = 8'h00;
    m_len = 8'h00;
    exp_ovr = 0;
    seen_ovr = 0;
    idle(3);
    sys_reset_n = 1'b1;
    idle(20);
    check_all_zero("post_reset");
    finish_case("reset");

    // Randomised traffic.
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 9);
      rdy_mode = ($urandom_range(0, 1) == 0) ? 0 : 3;
      if (kind == 0) begin
        n = $urandom_range(1, 3);
        repeat (n) begin
          b = 8'($urandom);
          if (b == HDR) b = 8'h55;
          send_byte(b);
          idle($urandom_range(0, 2));
        end
      end else if (kind == 1) begin
        send_byte(HDR);
        send_byte(8'($urandom));
        send_byte(8'($urandom_range(MAXL + 1, 255)));
      end else begin
        pl = '{};
        n = $urandom_range(0, MAXL);
        repeat (n) pl.push_back(8'($urandom));
        if (kind == 2) begin
          send_frame(8'($urandom), 8'($urandom_range(1, 255)), 3);
        end else if (kind == 3 && n > 0) begin
          rdy_mode = 1;
          i_byte_ready = 1'b0;
          send_frame(8'($urandom), 8'h00, 3);
          repeat ($urandom_range(1, 3)) begin
            idle($urandom_range(0, 2));
            send_byte(8'($urandom));
          end
          rdy_mode = 0;
        end else begin
          send_frame(8'($urandom), 8'h00, 3);
        end
      end
      finish_case("random");
    end

    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
